ecc_telemetry_collector: RTL and testbench
==========================================

// Module: ecc_telemetry_collector
// PURPOSE
//  Receiving end of the ECC engine telemetry bus (syndrome, SBE/DBE/parity flags).
//  Timestamps each error event and buffers it in a FIFO drained by the ML engine over valid/ready.
//  Keeps saturating error counters and runs a windowed SBE-rate health FSM with an alarm pulse.
// PARAMETERS
//  ECC_WIDTH        8     syndrome width
//  CNT_WIDTH        16    width of each saturating counter
//  TS_WIDTH         32    free-running timestamp width
//  FIFO_DEPTH       8     event FIFO entries, power of 2, >=2
//  WINDOW_CYCLES    1024  SBE-rate observation window length in cycles, >=2
//  SBE_WARN_THRESH  4     SBEs per window that trigger WARN; 2x this value triggers ALARM
// PORTS
//  clk            in   1                    clock
//  rst_n          in   1                    reset, asynchronous, active-low
//  err_sbe        in   1                    single-bit error flag (one cycle per event)
//  err_dbe        in   1                    double-bit error flag
//  err_in_parity  in   1                    check-bit-only error flag
//  syndrome       in   ECC_WIDTH            syndrome, qualified by any err_* flag
//  clr_counts     in   1                    synchronous clear of counters, sticky flags and FSM
//  evt_valid      out  1                    FIFO head valid
//  evt_ready      in   1                    ML engine accepts head
//  evt_data       out  2+ECC_WIDTH+TS_WIDTH {type[1:0], syndrome, timestamp}
//  sbe_count      out  CNT_WIDTH            total SBEs, saturating
//  dbe_count      out  CNT_WIDTH            total DBEs, saturating
//  par_count      out  CNT_WIDTH            total parity-bit errors, saturating
//  fifo_overflow  out  1                    sticky: an event was dropped because the FIFO was full
//  health_state   out  2                    00 NORMAL, 01 WARN, 10 ALARM
//  alarm_irq      out  1                    one-cycle pulse on entry to ALARM
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, timestamp 0, window counter 0, FSM NORMAL.
//  Timestamp: increments every cycle, wraps modulo 2^TS_WIDTH, not affected by clr_counts.
//  Event: a cycle with any err_* flag set. When flags coincide, priority is DBE > PAR > SBE.
//   Type codes: 01 SBE, 10 DBE, 11 PAR.
//   Only the winning type is counted and pushed.
//   The entry carries the timestamp of the input cycle.
//  Latency: input in cycle N -> counters and FIFO updated at N+1; evt_valid=1 at N+1 if FIFO was empty.
//  FIFO: first-word-fall-through. A pop occurs when evt_valid && evt_ready.
//   While evt_valid && !evt_ready, evt_data stays stable.
//   evt_data is don't-care while evt_valid=0.
//   Full with no pop: the event is dropped, fifo_overflow is set, and the event is still counted.
//   Full with a pop in the same cycle: the push is accepted.
//   Empty: evt_ready is ignored.
//  Counters: +1 per event of their type; hold at all-ones, no wrap.
//  clr_counts:
//   Zeroes counters, fifo_overflow, window counter and window SBE count; forces FSM to NORMAL.
//   Takes priority over a same-cycle increment, so that event is not counted.
//   That event is still pushed. Does not flush the FIFO.
//  Window: counter runs 0..WINDOW_CYCLES-1 and wraps. win_sbe counts SBEs in the current window, saturating.
//   Evaluation happens on the last window cycle and includes that cycle's SBE; win_sbe then restarts at 0.
//  FSM (transitions take effect on the next cycle):
//   NORMAL -> WARN   : window end with win_sbe >= SBE_WARN_THRESH
//   NORMAL -> ALARM  : window end with win_sbe >= 2*SBE_WARN_THRESH
//   WARN   -> ALARM  : window end with win_sbe >= 2*SBE_WARN_THRESH
//   WARN   -> NORMAL : window end with win_sbe == 0; otherwise stays WARN
//   any    -> ALARM  : any DBE event, immediately
//   ALARM  -> NORMAL : clr_counts only (ALARM is sticky)
//   DBE with clr_counts in the same cycle: clr wins, result is NORMAL.
//   alarm_irq pulses for one cycle on each entry to ALARM, never while already in ALARM.
//  Asynchronous reset mid-operation: FIFO contents are discarded and all state returns to reset values.
// TESTING
//  T1: reset, one SBE with syndrome=8'h07 at ts=10, evt_ready=1
//      -> evt_valid at next cycle, evt_data={2'b01,8'h07,32'd10}; sbe_count=1.
//  T2: evt_ready=0, 9 events with FIFO_DEPTH=8
//      -> 8 entries held in order; fifo_overflow=1; 9th event counted but not stored.
//  T3: FIFO full, event in the same cycle as a pop -> event stored; fifo_overflow stays 0.
//  T4: 4 SBEs within one window -> WARN after window end.
//      Next window with 0 SBEs -> NORMAL. A window with 8 SBEs -> ALARM plus one alarm_irq pulse.
//  T5: DBE while NORMAL -> ALARM next cycle, dbe_count=1, one irq pulse.
//      Second DBE -> no new pulse. clr_counts -> NORMAL with all counts 0.
//  T6: force sbe_count to all-ones, then one more SBE -> count holds.
//      SBE and DBE in the same cycle -> only a DBE is counted and pushed.

Source files
------------

// File: rtl/ecc_telemetry_collector.sv
// ECC telemetry sink: timestamps error events into a FWFT FIFO, keeps saturating counters, runs SBE-rate health FSM.
// Latency: input cycle N updates counters/FIFO/FSM at N+1; evt_valid/evt_ready backpressure, full FIFO drops and flags overflow.

module ecc_telemetry_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic             valid,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

module ecc_telemetry_collector #(
    parameter int ECC_WIDTH       = 8,
    parameter int CNT_WIDTH       = 16,
    parameter int TS_WIDTH        = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int WINDOW_CYCLES   = 1024,
    parameter int SBE_WARN_THRESH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            err_sbe,
    input  logic                            err_dbe,
    input  logic                            err_in_parity,
    input  logic [ECC_WIDTH-1:0]            syndrome,
    input  logic                            clr_counts,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [2+ECC_WIDTH+TS_WIDTH-1:0] evt_data,
    output logic [CNT_WIDTH-1:0]            sbe_count,
    output logic [CNT_WIDTH-1:0]            dbe_count,
    output logic [CNT_WIDTH-1:0]            par_count,
    output logic                            fifo_overflow,
    output logic [1:0]                      health_state,
    output logic                            alarm_irq
);
    localparam int EW    = 2 + ECC_WIDTH + TS_WIDTH;
    localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int SW    = $clog2(2 * SBE_WARN_THRESH + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [SW-1:0]    WARN_TH  = SW'(SBE_WARN_THRESH);
    localparam logic [SW-1:0]    ALARM_TH = SW'(2 * SBE_WARN_THRESH);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        WARN   = 2'b01,
        ALARM  = 2'b10
    } health_t;

    health_t          state, state_nxt;
    logic [TS_WIDTH-1:0] ts;
    logic [WIN_W-1:0] win_cnt;
    logic [SW-1:0]    win_sbe;
    logic [SW-1:0]    win_total;
    logic             win_last;
    logic             is_sbe, is_dbe, is_par, any_evt;
    logic [1:0]       evt_type;
    logic             fifo_full, push, pop;

    // Only the highest-priority flag becomes the event: DBE > PAR > SBE.
    assign is_dbe   = err_dbe;
    assign is_par   = !err_dbe && err_in_parity;
    assign is_sbe   = !err_dbe && !err_in_parity && err_sbe;
    assign any_evt  = err_dbe || err_in_parity || err_sbe;
    assign evt_type = is_dbe ? 2'b10 : (is_par ? 2'b11 : 2'b01);

    assign pop  = evt_valid && evt_ready;
    assign push = any_evt && (!fifo_full || pop);

    ecc_telemetry_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({evt_type, syndrome, ts}),
        .full    (fifo_full),
        .rd_en   (pop),
        .valid   (evt_valid),
        .rd_data (evt_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_count     <= '0;
            dbe_count     <= '0;
            par_count     <= '0;
            fifo_overflow <= 1'b0;
        end else if (clr_counts) begin
            sbe_count     <= '0;
            dbe_count     <= '0;
            par_count     <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (is_sbe && sbe_count != '1) sbe_count <= sbe_count + 1'b1;
            if (is_dbe && dbe_count != '1) dbe_count <= dbe_count + 1'b1;
            if (is_par && par_count != '1) par_count <= par_count + 1'b1;
            if (any_evt && fifo_full && !pop) fifo_overflow <= 1'b1;
        end
    end

    // The last window cycle's own SBE is folded in before evaluation.
    assign win_last  = (win_cnt == WIN_LAST);
    assign win_total = (is_sbe && win_sbe != '1) ? win_sbe + 1'b1 : win_sbe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            win_sbe <= '0;
        end else if (clr_counts) begin
            win_cnt <= '0;
            win_sbe <= '0;
        end else if (win_last) begin
            win_cnt <= '0;
            win_sbe <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            win_sbe <= win_total;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr_counts) begin
            state_nxt = NORMAL;
        end else if (is_dbe) begin
            state_nxt = ALARM;
        end else if (win_last) begin
            case (state)
                NORMAL: begin
                    if (win_total >= ALARM_TH)     state_nxt = ALARM;
                    else if (win_total >= WARN_TH) state_nxt = WARN;
                end
                WARN: begin
                    if (win_total >= ALARM_TH) state_nxt = ALARM;
                    else if (win_total == '0)  state_nxt = NORMAL;
                end
                ALARM:   state_nxt = ALARM;
                default: state_nxt = NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= NORMAL;
            alarm_irq <= 1'b0;
        end else begin
            state     <= state_nxt;
            alarm_irq <= (state_nxt == ALARM) && (state != ALARM);
        end
    end

    assign health_state = state;
endmodule

// File: tb/tb_ecc_telemetry_collector.sv
// Directed bench for ecc_telemetry_collector with a short window and 4-bit counters.
module tb_ecc_telemetry_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_sbe = 1'b0, err_dbe = 1'b0, err_in_parity = 1'b0;
    logic [7:0]  syndrome = 8'h00;
    logic        clr_counts = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [41:0] evt_data;
    logic [3:0]  sbe_count, dbe_count, par_count;
    logic        fifo_overflow;
    logic [1:0]  health_state;
    logic        alarm_irq;

    logic [1:0]  o_type;
    logic [7:0]  o_syn;
    logic [31:0] o_ts;
    assign o_type = evt_data[41:40];
    assign o_syn  = evt_data[39:32];
    assign o_ts   = evt_data[31:0];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] exp_ts [16];

    ecc_telemetry_collector #(
        .ECC_WIDTH(8), .CNT_WIDTH(4), .TS_WIDTH(32),
        .FIFO_DEPTH(8), .WINDOW_CYCLES(32), .SBE_WARN_THRESH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .err_sbe(err_sbe), .err_dbe(err_dbe),
        .err_in_parity(err_in_parity), .syndrome(syndrome), .clr_counts(clr_counts),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .sbe_count(sbe_count), .dbe_count(dbe_count), .par_count(par_count),
        .fifo_overflow(fifo_overflow), .health_state(health_state), .alarm_irq(alarm_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({evt_valid, sbe_count, dbe_count, par_count, fifo_overflow, health_state, alarm_irq} !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {evt_valid, sbe_count, dbe_count, par_count, fifo_overflow, health_state, alarm_irq});
        end
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_single_event();
        evt_ready = 1'b1;
        idle(10);
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL t1_idle_valid: got %b expected 0", evt_valid); end
        err_sbe = 1'b1; syndrome = 8'h07;
        tick();
        err_sbe = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid: got %b expected 1", evt_valid); end
        n_cmp++;
        if (evt_data !== {2'b01, 8'h07, 32'd10}) begin
            n_bad++; $display("FAIL t1_data: got %h expected %h", evt_data, {2'b01, 8'h07, 32'd10});
        end
        n_cmp++;
        if (sbe_count !== 4'd1) begin n_bad++; $display("FAIL t1_sbe_count: got %0d expected 1", sbe_count); end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL t1_popped: got %b expected 0", evt_valid); end
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        clr_counts = 1'b1; tick(); clr_counts = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            err_sbe = 1'b1; syndrome = 8'(i); exp_ts[i] = 32'(cyc);
            tick();
        end
        err_sbe = 1'b0;
        n_cmp++;
        if (sbe_count !== 4'd9) begin n_bad++; $display("FAIL t2_sbe_count: got %0d expected 9", sbe_count); end
        n_cmp++;
        if (fifo_overflow !== 1'b1) begin n_bad++; $display("FAIL t2_overflow: got %b expected 1", fifo_overflow); end
        tick();
        n_cmp++;
        if (o_syn !== 8'd1) begin n_bad++; $display("FAIL t2_stall_stable: got %h expected 01", o_syn); end
        evt_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_data !== {2'b01, 8'(i), exp_ts[i]}) begin
                n_bad++;
                $display("FAIL t2_entry%0d: got v=%b %h expected v=1 %h", i, evt_valid, evt_data, {2'b01, 8'(i), exp_ts[i]});
            end
            tick();
        end
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL t2_drained: got %b expected 0", evt_valid); end
    endtask

    task automatic test_full_pop();
        evt_ready = 1'b0;
        clr_counts = 1'b1; tick(); clr_counts = 1'b0;
        for (int i = 0; i < 9; i++) begin
            err_in_parity = 1'b1; syndrome = 8'(8'h10 + i); exp_ts[i] = 32'(cyc);
            evt_ready = (i == 8);
            tick();
        end
        err_in_parity = 1'b0; evt_ready = 1'b0;
        n_cmp++;
        if (fifo_overflow !== 1'b0) begin n_bad++; $display("FAIL t3_overflow: got %b expected 0", fifo_overflow); end
        n_cmp++;
        if (par_count !== 4'd9) begin n_bad++; $display("FAIL t3_par_count: got %0d expected 9", par_count); end
        evt_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_data !== {2'b11, 8'(8'h10 + i), exp_ts[i]}) begin
                n_bad++;
                $display("FAIL t3_entry%0d: got v=%b %h expected v=1 %h", i, evt_valid, evt_data, {2'b11, 8'(8'h10 + i), exp_ts[i]});
            end
            tick();
        end
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL t3_drained: got %b expected 0", evt_valid); end
    endtask

    task automatic test_window_fsm();
        evt_ready = 1'b1;
        clr_counts = 1'b1; tick(); clr_counts = 1'b0;
        // Window 1: SBEs at cycles 0..2 plus one on the last cycle (31).
        err_sbe = 1'b1; idle(3); err_sbe = 1'b0;
        idle(28);
        n_cmp++;
        if (health_state !== 2'b00) begin n_bad++; $display("FAIL t4_before_end: got %b expected 00", health_state); end
        err_sbe = 1'b1; tick(); err_sbe = 1'b0;
        n_cmp++;
        if (health_state !== 2'b01) begin n_bad++; $display("FAIL t4_warn: got %b expected 01", health_state); end
        idle(32);
        n_cmp++;
        if (health_state !== 2'b00) begin n_bad++; $display("FAIL t4_back_normal: got %b expected 00", health_state); end
        err_sbe = 1'b1; idle(8); err_sbe = 1'b0;
        idle(23);
        n_cmp++;
        if (health_state !== 2'b00 || alarm_irq !== 1'b0) begin
            n_bad++; $display("FAIL t4_pre_alarm: got %b/%b expected 00/0", health_state, alarm_irq);
        end
        tick();
        n_cmp++;
        if (health_state !== 2'b10 || alarm_irq !== 1'b1) begin
            n_bad++; $display("FAIL t4_alarm: got %b/%b expected 10/1", health_state, alarm_irq);
        end
        tick();
        n_cmp++;
        if (health_state !== 2'b10 || alarm_irq !== 1'b0) begin
            n_bad++; $display("FAIL t4_irq_once: got %b/%b expected 10/0", health_state, alarm_irq);
        end
    endtask

    task automatic test_dbe_alarm();
        evt_ready = 1'b1;
        clr_counts = 1'b1; tick(); clr_counts = 1'b0;
        n_cmp++;
        if (health_state !== 2'b00) begin n_bad++; $display("FAIL t5_cleared: got %b expected 00", health_state); end
        err_dbe = 1'b1; syndrome = 8'hAA; tick(); err_dbe = 1'b0;
        n_cmp++;
        if (health_state !== 2'b10 || alarm_irq !== 1'b1 || dbe_count !== 4'd1) begin
            n_bad++; $display("FAIL t5_dbe: got %b/%b/%0d expected 10/1/1", health_state, alarm_irq, dbe_count);
        end
        tick();
        n_cmp++;
        if (alarm_irq !== 1'b0) begin n_bad++; $display("FAIL t5_irq_drop: got %b expected 0", alarm_irq); end
        err_dbe = 1'b1; tick(); err_dbe = 1'b0;
        n_cmp++;
        if (alarm_irq !== 1'b0 || dbe_count !== 4'd2) begin
            n_bad++; $display("FAIL t5_second_dbe: got %b/%0d expected 0/2", alarm_irq, dbe_count);
        end
        clr_counts = 1'b1; tick(); clr_counts = 1'b0;
        n_cmp++;
        if ({health_state, sbe_count, dbe_count, par_count, fifo_overflow, alarm_irq} !== 16'h0) begin
            n_bad++; $display("FAIL t5_clr: got %h expected 0", {health_state, sbe_count, dbe_count, par_count, fifo_overflow, alarm_irq});
        end
        evt_ready = 1'b0;
        err_dbe = 1'b1; clr_counts = 1'b1; syndrome = 8'hC3; tick();
        err_dbe = 1'b0; clr_counts = 1'b0;
        n_cmp++;
        if (health_state !== 2'b00 || alarm_irq !== 1'b0 || dbe_count !== 4'd0) begin
            n_bad++; $display("FAIL t5_clr_wins: got %b/%b/%0d expected 00/0/0", health_state, alarm_irq, dbe_count);
        end
        n_cmp++;
        if (evt_valid !== 1'b1 || o_type !== 2'b10 || o_syn !== 8'hC3) begin
            n_bad++; $display("FAIL t5_clr_push: got v=%b %b %h expected v=1 10 c3", evt_valid, o_type, o_syn);
        end
        evt_ready = 1'b1; tick();
    endtask

    task automatic test_saturation();
        evt_ready = 1'b1;
        err_sbe = 1'b1; clr_counts = 1'b1; syndrome = 8'h55; tick(); clr_counts = 1'b0;
        err_sbe = 1'b0;
        n_cmp++;
        if (sbe_count !== 4'd0 || evt_valid !== 1'b1 || o_syn !== 8'h55) begin
            n_bad++; $display("FAIL t6_clr_sbe: got %0d v=%b %h expected 0 v=1 55", sbe_count, evt_valid, o_syn);
        end
        err_sbe = 1'b1; idle(15); err_sbe = 1'b0;
        n_cmp++;
        if (sbe_count !== 4'hF) begin n_bad++; $display("FAIL t6_reach_max: got %0d expected 15", sbe_count); end
        err_sbe = 1'b1; tick(); err_sbe = 1'b0;
        n_cmp++;
        if (sbe_count !== 4'hF) begin n_bad++; $display("FAIL t6_hold: got %0d expected 15", sbe_count); end
        idle(2);
        err_sbe = 1'b1; err_dbe = 1'b1; syndrome = 8'h99; tick();
        err_sbe = 1'b0; err_dbe = 1'b0;
        n_cmp++;
        if (dbe_count !== 4'd1 || sbe_count !== 4'hF) begin
            n_bad++; $display("FAIL t6_dbe_prio_cnt: got dbe=%0d sbe=%0d expected 1/15", dbe_count, sbe_count);
        end
        n_cmp++;
        if (evt_valid !== 1'b1 || o_type !== 2'b10 || o_syn !== 8'h99) begin
            n_bad++; $display("FAIL t6_dbe_prio_push: got v=%b %b %h expected v=1 10 99", evt_valid, o_type, o_syn);
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL t6_single_push: got %b expected 0", evt_valid); end
    endtask

    task automatic test_async_reset();
        evt_ready = 1'b0;
        err_sbe = 1'b1; idle(2); err_sbe = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({evt_valid, sbe_count, dbe_count, health_state} !== 11'h0) begin
            n_bad++; $display("FAIL t7_async_clear: got %h expected 0", {evt_valid, sbe_count, dbe_count, health_state});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0;
        err_sbe = 1'b1; syndrome = 8'h3C; tick(); err_sbe = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_data !== {2'b01, 8'h3C, 32'd0}) begin
            n_bad++; $display("FAIL t7_ts_restart: got v=%b %h expected v=1 %h", evt_valid, evt_data, {2'b01, 8'h3C, 32'd0});
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_overflow();
        test_full_pop();
        test_window_fsm();
        test_dbe_alarm();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
